// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter: shares one single-ported memory bus between YARP
// instruction fetch and data load/store. Data wins by default, but a waiting
// fetch is forced through after STARVE_LIMIT consecutive data grants. Only one
// transaction is outstanding at a time. Misaligned or illegal data accesses
// are answered locally with an error response and never reach memory.
module yarp_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              imem_req_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    output logic              imem_gnt_o,
    output logic              imem_rvalid_o,
    output logic [DATA_W-1:0] imem_rdata_o,
    input  logic              dmem_req_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic              dmem_wr_i,
    input  logic [1:0]        dmem_byte_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    output logic              dmem_gnt_o,
    output logic              dmem_rvalid_o,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              dmem_err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [1:0]        mem_byte_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_t;

    // Size/alignment legality: Byte always legal, Half needs addr[0]=0,
    // Word needs addr[1:0]=0, size code 10 is illegal.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b11:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    owner_t            owner_r;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wr_r;
    logic [1:0]        mem_byte_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic              fetch_win_s;
    logic              data_win_s;
    logic              data_bad_s;
    logic              imem_gnt_s;
    logic              imem_rvalid_s;
    logic [DATA_W-1:0] imem_rdata_s;
    logic              dmem_gnt_s;
    logic              dmem_rvalid_s;
    logic [DATA_W-1:0] dmem_rdata_s;
    logic              dmem_err_s;

    assign fetch_win_s = imem_req_i & (~dmem_req_i | (starve_cnt_r == STARVE_MAX));
    assign data_win_s  = dmem_req_i & ~fetch_win_s;
    assign data_bad_s  = access_bad(dmem_byte_i, dmem_addr_i[1:0]);

    // State register; async reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, then issue, wait for the response.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_win_s) begin
                    state_next_s = ST_ISSUE;
                end else if (data_win_s) begin
                    state_next_s = data_bad_s ? ST_ERR : ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = mem_gnt_i ? ST_WAIT : ST_ISSUE;
            ST_WAIT:  state_next_s = mem_rvalid_i ? ST_IDLE : ST_WAIT;
            ST_ERR:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: route gnt/rvalid/rdata only to the current owner.
    always_comb begin
        imem_gnt_s    = 1'b0;
        imem_rvalid_s = 1'b0;
        imem_rdata_s  = {DATA_W{1'b0}};
        dmem_gnt_s    = 1'b0;
        dmem_rvalid_s = 1'b0;
        dmem_rdata_s  = {DATA_W{1'b0}};
        dmem_err_s    = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                if (owner_r == OWN_IMEM) begin
                    imem_gnt_s = mem_gnt_i;
                end else if (owner_r == OWN_DMEM) begin
                    dmem_gnt_s = mem_gnt_i;
                end else begin
                    imem_gnt_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (owner_r == OWN_IMEM) begin
                    imem_rvalid_s = mem_rvalid_i;
                    imem_rdata_s  = mem_rvalid_i ? mem_rdata_i : {DATA_W{1'b0}};
                end else if (owner_r == OWN_DMEM) begin
                    dmem_rvalid_s = mem_rvalid_i;
                    dmem_rdata_s  = mem_rvalid_i ? mem_rdata_i : {DATA_W{1'b0}};
                end else begin
                    imem_rvalid_s = 1'b0;
                end
            end
            ST_ERR: begin
                dmem_gnt_s    = 1'b1;
                dmem_rvalid_s = 1'b1;
                dmem_err_s    = 1'b1;
            end
            default: begin
                imem_gnt_s = 1'b0;
            end
        endcase
    end

    // Owner tracking: recorded when the winner is chosen in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r <= OWN_NONE;
        end else if (state_r == ST_IDLE) begin
            if (fetch_win_s) begin
                owner_r <= OWN_IMEM;
            end else if (data_win_s) begin
                owner_r <= OWN_DMEM;
            end else begin
                owner_r <= OWN_NONE;
            end
        end else begin
            owner_r <= owner_r;
        end
    end

    // Memory request and payload registers; payload is frozen until the next win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wr_r    <= 1'b0;
            mem_byte_r  <= 2'b00;
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_req_r <= (state_next_s == ST_ISSUE);
            if ((state_r == ST_IDLE) && fetch_win_s) begin
                mem_addr_r  <= imem_addr_i;
                mem_wr_r    <= 1'b0;
                mem_byte_r  <= 2'b11;
                mem_wdata_r <= {DATA_W{1'b0}};
            end else if ((state_r == ST_IDLE) && data_win_s && !data_bad_s) begin
                mem_addr_r  <= dmem_addr_i;
                mem_wr_r    <= dmem_wr_i;
                mem_byte_r  <= dmem_byte_i;
                mem_wdata_r <= dmem_wdata_i;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wr_r    <= mem_wr_r;
                mem_byte_r  <= mem_byte_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Starvation counter: counts data grants while a fetch waits, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (((state_r == ST_IDLE) && !imem_req_i) || imem_gnt_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (dmem_gnt_s && imem_req_i && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign imem_gnt_o    = imem_gnt_s;
    assign imem_rvalid_o = imem_rvalid_s;
    assign imem_rdata_o  = imem_rdata_s;
    assign dmem_gnt_o    = dmem_gnt_s;
    assign dmem_rvalid_o = dmem_rvalid_s;
    assign dmem_rdata_o  = dmem_rdata_s;
    assign dmem_err_o    = dmem_err_s;
    assign mem_req_o     = mem_req_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_wr_o      = mem_wr_r;
    assign mem_byte_o    = mem_byte_r;
    assign mem_wdata_o   = mem_wdata_r;

endmodule
